// File: rtl/input_port_pkg.sv
// Shared constants for the input port: debounce state encodings and a
// parameter sanity helper used at elaboration time.
package input_port_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    QUAL_HIGH   = 2'b01,
    HIGH_STABLE = 2'b10,
    QUAL_LOW    = 2'b11
  } deb_state_t;

  // True when a counter of cnt_w bits can hold the terminal count cycles-1.
  function automatic bit cnt_fits(input int cnt_w, input int cycles);
    longint unsigned cap;
    if (cnt_w <= 0 || cnt_w > 62) return (cnt_w > 62);
    cap = longint'(1) << cnt_w;
    return (longint'(cycles) - 1) < longint'(cap);
  endfunction

endpackage

// File: rtl/input_port_sync_2ff.sv
// Two-stage synchronizer for asynchronous pins, cleared by synchronous reset.
module sync_2ff #(
  parameter int Width = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [Width-1:0] D,
  output logic [Width-1:0] Q
);

  logic [Width-1:0] q_p0;
  logic [Width-1:0] q_p1;

  // Stage 0 catches the async level, stage 1 lets metastability settle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_p0 <= '0;
      q_p1 <= '0;
    end else begin
      q_p0 <= D;
      q_p1 <= q_p0;
    end
  end

  assign Q = q_p1;

endmodule

// File: rtl/input_port.sv
// CPU-readable input register: synchronizes an external pin bank and a
// bouncing strobe, debounces the strobe, and captures the pins once per
// accepted rising edge with Ready/Overrun handshake flags.
module input_port
  import input_port_pkg::*;
#(
  parameter int DataWidth      = 16,
  parameter int PinWidth       = 8,
  parameter int DebounceCycles = 16,
  parameter int CntWidth       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [PinWidth-1:0]  Pins,
  input  logic                 Strobe,
  input  logic                 Rd,
  output logic [DataWidth-1:0] InReg,
  output logic                 Ready,
  output logic                 Overrun
);

  if (PinWidth > DataWidth || PinWidth < 1 || DebounceCycles < 2 ||
      !cnt_fits(CntWidth, DebounceCycles)) begin : g_bad_params
    $error("input_port: invalid parameter combination");
  end

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  logic [PinWidth-1:0] s_pins;
  logic [0:0]          s_strobe_vec;
  logic                s_strobe;
  deb_state_t          state;
  logic [CntWidth-1:0] cnt;
  logic                capture;

  sync_2ff #(.Width(PinWidth)) u_sync_pins (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (Pins),
    .Q     (s_pins)
  );

  sync_2ff #(.Width(1)) u_sync_strobe (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (Strobe),
    .Q     (s_strobe_vec)
  );

  assign s_strobe = s_strobe_vec[0];

  // A capture fires on the edge that accepts the final high sample, so the
  // register update below lands on that same edge.
  assign capture = (state == QUAL_HIGH) && s_strobe && (cnt == CntLast);

  // Debounce FSM: a level change is accepted only after DebounceCycles
  // consecutive synchronized samples; any reversal restarts qualification.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= LOW_STABLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        LOW_STABLE: begin
          if (s_strobe) begin
            state <= QUAL_HIGH;
            cnt   <= CntOne;
          end else begin
            cnt   <= '0;
          end
        end
        QUAL_HIGH: begin
          if (!s_strobe) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CntOne;
          end
        end
        HIGH_STABLE: begin
          if (!s_strobe) begin
            state <= QUAL_LOW;
            cnt   <= CntOne;
          end
        end
        QUAL_LOW: begin
          if (s_strobe) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CntOne;
          end
        end
        default: begin
          state <= LOW_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Input register and handshake: a capture while unread data is pending
  // is dropped and flagged, unless the CPU reads on that same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      InReg   <= '0;
      Ready   <= 1'b0;
      Overrun <= 1'b0;
    end else if (capture) begin
      if (!Ready || Rd) begin
        InReg   <= DataWidth'(s_pins);
        Ready   <= 1'b1;
        Overrun <= 1'b0;
      end else begin
        Overrun <= 1'b1;
      end
    end else if (Rd && Ready) begin
      Ready   <= 1'b0;
      Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with a 4-sample debounce window.
module tb_input_port;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  Pins;
  logic        Strobe;
  logic        Rd;
  logic [15:0] InReg;
  logic        Ready;
  logic        Overrun;

  int n_cmp = 0;
  int n_err = 0;

  input_port #(
    .DataWidth      (16),
    .PinWidth       (8),
    .DebounceCycles (4),
    .CntWidth       (8)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Pins    (Pins),
    .Strobe  (Strobe),
    .Rd      (Rd),
    .InReg   (InReg),
    .Ready   (Ready),
    .Overrun (Overrun)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_pulse();
    Rd = 1'b1;
    tick(1);
    Rd = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Pins = 8'h00; Strobe = 1'b0; Rd = 1'b0;
    tick(3);
    check("rst_inreg",   InReg,          16'h0000);
    check("rst_ready",   16'(Ready),     16'h0000);
    check("rst_overrun", 16'(Overrun),   16'h0000);
    Reset = 1'b0;
    tick(2);

    // Basic capture: edges N..N+4 show nothing, N+5 shows the data.
    Pins = 8'hA5; Strobe = 1'b1;
    tick(5);
    check("basic_not_early", 16'(Ready), 16'h0000);
    tick(1);
    check("basic_ready",   16'(Ready),   16'h0001);
    check("basic_inreg",   InReg,        16'h00A5);
    check("basic_overrun", 16'(Overrun), 16'h0000);
    rd_pulse();
    check("basic_rd_ready", 16'(Ready), 16'h0000);
    check("basic_rd_hold",  InReg,      16'h00A5);
    Strobe = 1'b0;
    tick(10);

    // Rd with nothing pending changes nothing.
    rd_pulse();
    check("idle_rd_ready", 16'(Ready), 16'h0000);
    check("idle_rd_inreg", InReg,      16'h00A5);

    // Bounce rejection: 3 high, 1 low, 3 high, low.
    Pins = 8'h5A;
    Strobe = 1'b1; tick(3);
    Strobe = 1'b0; tick(1);
    Strobe = 1'b1; tick(3);
    Strobe = 1'b0; tick(8);
    check("bounce_ready", 16'(Ready), 16'h0000);
    check("bounce_inreg", InReg,      16'h00A5);
    Strobe = 1'b1;
    tick(5);
    check("bounce_ok_early", 16'(Ready), 16'h0000);
    tick(1);
    check("bounce_ok_ready", 16'(Ready), 16'h0001);
    check("bounce_ok_inreg", InReg,      16'h005A);
    rd_pulse();
    tick(10);
    check("bounce_one_only", 16'(Ready), 16'h0000);
    Strobe = 1'b0;
    tick(8);

    // Overrun: second capture without a read is dropped.
    Pins = 8'h11; Strobe = 1'b1;
    tick(6);
    check("ovr_first", InReg, 16'h0011);
    Strobe = 1'b0;
    tick(8);
    Pins = 8'h22; Strobe = 1'b1;
    tick(6);
    check("ovr_inreg",   InReg,        16'h0011);
    check("ovr_ready",   16'(Ready),   16'h0001);
    check("ovr_flag",    16'(Overrun), 16'h0001);
    rd_pulse();
    check("ovr_rd_ready", 16'(Ready),   16'h0000);
    check("ovr_rd_flag",  16'(Overrun), 16'h0000);
    Strobe = 1'b0;
    tick(8);

    // Rd on the capture edge: old byte consumed, new byte loaded.
    Pins = 8'h33; Strobe = 1'b1;
    tick(6);
    check("coin_first", InReg, 16'h0033);
    Strobe = 1'b0;
    tick(8);
    Pins = 8'h44; Strobe = 1'b1;
    tick(5);
    Rd = 1'b1;
    tick(1);
    Rd = 1'b0;
    check("coin_inreg",   InReg,        16'h0044);
    check("coin_ready",   16'(Ready),   16'h0001);
    check("coin_overrun", 16'(Overrun), 16'h0000);
    rd_pulse();
    Strobe = 1'b0;
    tick(8);

    // Reset during QUAL_HIGH with data pending.
    Pins = 8'h55; Strobe = 1'b1;
    tick(6);
    check("rmid_pre", InReg, 16'h0055);
    Strobe = 1'b0;
    tick(8);
    Pins = 8'h66; Strobe = 1'b1;
    tick(3);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("rmid_inreg",   InReg,        16'h0000);
    check("rmid_ready",   16'(Ready),   16'h0000);
    check("rmid_overrun", 16'(Overrun), 16'h0000);
    tick(5);
    check("rmid_full_qual", 16'(Ready), 16'h0000);
    tick(1);
    check("rmid_cap_ready", 16'(Ready), 16'h0001);
    check("rmid_cap_inreg", InReg,      16'h0066);
    Strobe = 1'b0;
    rd_pulse();
    tick(8);

    // Long hold gives one capture; release and re-raise gives another.
    Pins = 8'h77; Strobe = 1'b1;
    tick(6);
    check("long_first", InReg, 16'h0077);
    rd_pulse();
    tick(100);
    check("long_no_repeat", 16'(Ready), 16'h0000);
    Strobe = 1'b0;
    tick(8);
    Pins = 8'h88; Strobe = 1'b1;
    tick(6);
    check("long_second_ready",   16'(Ready),   16'h0001);
    check("long_second_inreg",   InReg,        16'h0088);
    check("long_second_overrun", 16'(Overrun), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_port.md
Name: input_port

Overview:
- Input-direction counterpart of the CPU output register path on the FPGA top level.
- Samples an external 8-bit pin bank when an external "data valid" strobe pin rises. The strobe is debounced, since it comes from a manual switch like the clock/reset switches.
- Presents the captured byte, zero-extended, to the CPU as a readable input register with Ready/Overrun flags.
- The CPU consumes data by pulsing Rd.

Parameters:
- DataWidth, 16, width of InReg seen by the CPU (matches CPU data width).
- PinWidth, 8, number of external data pins (PinWidth <= DataWidth).
- DebounceCycles, 16, consecutive stable synchronized strobe samples required to accept a level change (>= 2).
- CntWidth, 8, debounce counter width; must hold DebounceCycles-1.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Pins  input  PinWidth  asynchronous external data pins.
- Strobe  input  1  asynchronous external data-valid pin; may bounce.
- Rd  input  1  CPU read/acknowledge pulse, synchronous to Clk.
- InReg  output  DataWidth  last captured data, zero-extended.
- Ready  output  1  unread data present in InReg.
- Overrun  output  1  sticky; a capture was dropped while Ready=1.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high. While Reset=1 at a posedge: InReg=0, Ready=0, Overrun=0, both synchronizers=0, debounce state=LOW_STABLE, counter=0. Reset overrides Rd and any capture in the same cycle. Reset mid-qualification discards the partial count.
- Synchronization: Pins and Strobe each pass through two flops (sPins, sStrobe), giving 2 cycles of latency. All downstream logic uses only the synchronized values.
- Debounce FSM, 4 states:
  - LOW_STABLE: sStrobe=1 -> QUAL_HIGH, counter=1; else stay, counter=0.
  - QUAL_HIGH: sStrobe=0 -> LOW_STABLE, counter=0. sStrobe=1 with counter==DebounceCycles-1 -> HIGH_STABLE, counter=0, assert one-cycle internal capture. Otherwise counter+1.
  - HIGH_STABLE: sStrobe=0 -> QUAL_LOW, counter=1; else stay.
  - QUAL_LOW: sStrobe=1 -> HIGH_STABLE, counter=0. sStrobe=0 with counter==DebounceCycles-1 -> LOW_STABLE, counter=0. Otherwise counter+1.
- Capture rules:
  - Exactly one capture per accepted low->high transition. High->low acceptance produces no capture.
  - Strobe glitches shorter than DebounceCycles synchronized samples produce no capture.
- Latency: Strobe held high from posedge N (first sampling flop sees 1) -> capture registered at posedge N+1+DebounceCycles. Ready and InReg are visible after that edge. Pins must be stable from N-2 through capture.
- Capture action:
  - InReg = {zeros, sPins} as sampled on the capture edge; Ready=1.
  - Upper DataWidth-PinWidth bits are always 0.
- Read handshake:
  - Rd=1 with Ready=1 -> Ready=0 and Overrun=0 next edge.
  - InReg holds its value until the next capture; it is not cleared by Rd.
  - Rd with Ready=0 has no effect.
- Simultaneous events:
  - Capture with Ready=1 and Rd=0: new data is dropped, InReg is unchanged, Overrun=1 (sticky), Ready stays 1.
  - Capture with Ready=1 and Rd=1: the old data is consumed, the new data loads, Ready stays 1, Overrun=0.
  - Capture with Ready=0: normal load.
- Counter width: counter saturation never occurs, because every transition resets the counter. CntWidth must be sized so that DebounceCycles-1 fits; a parameter check fails elaboration otherwise.

Decomposition:
- Shared constants include file (alongside the CPU definitions): debounce state encodings LOW_STABLE=2'b00, QUAL_HIGH=2'b01, HIGH_STABLE=2'b10, QUAL_LOW=2'b11.
- One sub-module, sync_2ff: parameter Width; ports Clk, Reset, D, Q; two-stage synchronizer with synchronous reset. Instantiated once for Pins (Width=PinWidth) and once for Strobe (Width=1).
- FSM, counter and register logic live in input_port.

Test Plan (DebounceCycles=4 unless noted):
- Basic capture: Pins=8'hA5, Strobe rises at N and held -> at N+5 InReg=16'h00A5, Ready=1, Overrun=0. Rd one cycle -> Ready=0, InReg stays 16'h00A5.
- Bounce rejection: Strobe high 3 cycles, low 1, high 3, low -> no capture, Ready stays 0. Then high 4+ cycles -> exactly one capture.
- Overrun: capture 8'h11, no Rd, release Strobe >= 4 cycles, capture 8'h22 -> InReg=16'h0011, Ready=1, Overrun=1. Rd -> Ready=0, Overrun=0.
- Rd coincident with capture: Ready=1 holding 8'h33, Rd asserted on the capture edge of 8'h44 -> InReg=16'h0044, Ready=1, Overrun=0.
- Reset mid-operation: Reset=1 during QUAL_HIGH with Ready=1 -> next edge InReg=0, Ready=0, Overrun=0. Strobe still high after reset release -> capture after a full 4-sample qualification, not earlier.
- Long hold: Strobe held high 100 cycles -> exactly one capture. Release and re-raise -> second capture.
